tx_report_scheduler: RTL and testbench

- Arbitrates three telemetry sources (alarm event, command acknowledge, periodic status) onto the single UART transmit byte channel.
- Frames each message, holds bytes under a valid/ready handshake, and issues status frames on an internal timer.
- Sits between the command/alarm/light/vent/door logic and the UART TX serializer; replaces the ad-hoc 2-second echo of the received byte.

---
 rtl/smarthome_pkg.sv | 39 +++
 rtl/tx_report_scheduler_if.sv | 14 +
 rtl/period_timer.sv | 27 ++
 rtl/tx_report_scheduler.sv | 157 +++++++++++++++
 tb/tb_tx_report_scheduler.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smarthome_pkg.sv
// Shared smart-home definitions: frame constants, TX scheduler state encoding,
// frame payload layout and the byte selector for a 5-byte report frame.
package smarthome_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(4);
    localparam logic [BYTE_W-1:0] FRAME_HDR   = 8'hA5;
    localparam logic [BYTE_W-1:0] TYPE_STATUS = 8'h01;
    localparam logic [BYTE_W-1:0] TYPE_ACK    = 8'h02;
    localparam logic [BYTE_W-1:0] TYPE_ALARM  = 8'h03;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] ftype;
        logic [BYTE_W-1:0] d0;
        logic [BYTE_W-1:0] d1;
    } frame_t;

    // Byte idx of the frame HDR, TYPE, D0, D1, CHK with CHK = TYPE ^ D0 ^ D1.
    function automatic logic [BYTE_W-1:0] frame_byte(input logic [BYTE_W-1:0] hdr,
                                                     input frame_t            f,
                                                     input logic [IDX_W-1:0]  idx);
        case (idx)
            IDX_W'(0): frame_byte = hdr;
            IDX_W'(1): frame_byte = f.ftype;
            IDX_W'(2): frame_byte = f.d0;
            IDX_W'(3): frame_byte = f.d1;
            default:   frame_byte = f.ftype ^ f.d0 ^ f.d1;
        endcase
    endfunction

endpackage

// File: rtl/tx_report_scheduler_if.sv
// UART TX byte channel with valid/ready handshake.
//   tx_data  : byte offered to the serializer
//   tx_valid : tx_data valid, held until accepted
//   tx_ready : serializer accepts the byte this cycle
interface tx_report_scheduler_if;
    import smarthome_pkg::*;

    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/period_timer.sv
// Free-running counter 0..PERIOD-1 with a terminal-count pulse.
//   clk, rst : clock, async active-high reset
//   tc_c     : high during the cycle the count equals PERIOD-1
module period_timer #(
    parameter int unsigned PERIOD = 100000000
) (
    input  logic clk,
    input  logic rst,
    output logic tc_c
);
    localparam int unsigned      CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tc_c = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tc_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/tx_report_scheduler.sv
// Arbitrates alarm, command-ack and periodic status reports onto the UART TX
// byte channel as 5-byte frames (HDR, TYPE, D0, D1, CHK).
//   clk, rst              : clock, async active-high reset
//   alarm_evt/sensor_snap : alarm trip pulse and sensor snapshot
//   ack_req/ack_code      : command-executed pulse and its code
//   lights/vents/alarm_armed/door_open : live status fields
//   tx                    : TX byte channel (master side)
//   busy                  : frame in progress
//   ack_overrun           : sticky, an ack request was overwritten
module tx_report_scheduler
    import smarthome_pkg::*;
#(
    parameter int unsigned       STATUS_PERIOD_CYCLES = 100000000,
    parameter logic [BYTE_W-1:0] FRAME_HDR            = smarthome_pkg::FRAME_HDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alarm_evt,
    input  logic [1:0]            sensor_snap,
    input  logic                  ack_req,
    input  logic [BYTE_W-1:0]     ack_code,
    input  logic [5:0]            lights,
    input  logic [3:0]            vents,
    input  logic                  alarm_armed,
    input  logic                  door_open,
    tx_report_scheduler_if.master tx,
    output logic                  busy,
    output logic                  ack_overrun
);
    tx_state_e         state_q, state_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    frame_t            frame_q, frame_nxt;
    logic [BYTE_W-1:0] tx_data_q, tx_data_nxt;
    logic              tx_valid_q, tx_valid_nxt;

    logic              alarm_pend_q, ack_pend_q, status_pend_q;
    logic [1:0]        snap_q;
    logic [BYTE_W-1:0] code_q;
    logic [BYTE_W-1:0] alarm_cnt_q;
    logic              ack_overrun_q;
    logic              busy_q;

    logic              grant_alarm_c, grant_ack_c, grant_status_c;
    logic              status_tick_c;

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign ack_overrun = ack_overrun_q;

    period_timer #(.PERIOD(STATUS_PERIOD_CYCLES)) u_period_timer (
        .clk  (clk),
        .rst  (rst),
        .tc_c (status_tick_c)
    );

    // Request capture: a new request wins over a same-cycle grant clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_pend_q  <= 1'b0;
            ack_pend_q    <= 1'b0;
            status_pend_q <= 1'b0;
            snap_q        <= '0;
            code_q        <= '0;
            alarm_cnt_q   <= '0;
            ack_overrun_q <= 1'b0;
        end else begin
            alarm_pend_q  <= alarm_evt     | (alarm_pend_q  & ~grant_alarm_c);
            ack_pend_q    <= ack_req       | (ack_pend_q    & ~grant_ack_c);
            status_pend_q <= status_tick_c | (status_pend_q & ~grant_status_c);
            if (alarm_evt) begin
                snap_q      <= sensor_snap;
                alarm_cnt_q <= alarm_cnt_q + BYTE_W'(1);
            end
            if (ack_req) begin
                code_q <= ack_code;
            end
            if (ack_req & ack_pend_q & ~grant_ack_c) begin
                ack_overrun_q <= 1'b1;
            end
        end
    end

    // Frame FSM state and registered TX outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            idx_q      <= idx_nxt;
            frame_q    <= frame_nxt;
            tx_data_q  <= tx_data_nxt;
            tx_valid_q <= tx_valid_nxt;
            busy_q     <= (state_nxt != IDLE);
        end
    end

    // Next state: fixed-priority grant in IDLE, byte stepping in SEND.
    always_comb begin
        state_nxt      = state_q;
        idx_nxt        = idx_q;
        frame_nxt      = frame_q;
        tx_data_nxt    = tx_data_q;
        tx_valid_nxt   = tx_valid_q;
        grant_alarm_c  = 1'b0;
        grant_ack_c    = 1'b0;
        grant_status_c = 1'b0;

        case (state_q)
            IDLE: begin
                tx_valid_nxt = 1'b0;
                if (alarm_pend_q) begin
                    grant_alarm_c = 1'b1;
                    frame_nxt     = '{ftype: TYPE_ALARM, d0: {6'b0, snap_q}, d1: alarm_cnt_q};
                end else if (ack_pend_q) begin
                    grant_ack_c = 1'b1;
                    frame_nxt   = '{ftype: TYPE_ACK, d0: code_q, d1: 8'h00};
                end else if (status_pend_q) begin
                    grant_status_c = 1'b1;
                    frame_nxt      = '{ftype: TYPE_STATUS,
                                       d0: {2'b0, lights},
                                       d1: {2'b0, door_open, alarm_armed, vents}};
                end
                if (alarm_pend_q | ack_pend_q | status_pend_q) begin
                    state_nxt    = SEND;
                    idx_nxt      = '0;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = FRAME_HDR;
                end
            end
            SEND: begin
                if (tx_valid_q & tx.tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_nxt    = GAP;
                        tx_valid_nxt = 1'b0;
                    end else begin
                        idx_nxt     = idx_q + IDX_W'(1);
                        tx_data_nxt = frame_byte(FRAME_HDR, frame_q, idx_nxt);
                    end
                end
            end
            GAP: begin
                state_nxt    = IDLE;
                tx_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt    = IDLE;
                tx_valid_nxt = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_tx_report_scheduler.sv
// Directed bench for tx_report_scheduler: table of single-frame requests plus
// hand sequences for latency, backpressure, priority, overrun, reset, status
// timing and alarm count wrap.
module tb_tx_report_scheduler;
    localparam int unsigned PERIOD = 100;

    logic       clk;
    logic       rst;
    logic       alarm_evt;
    logic [1:0] sensor_snap;
    logic       ack_req;
    logic [7:0] ack_code;
    logic [5:0] lights;
    logic [3:0] vents;
    logic       alarm_armed;
    logic       door_open;
    logic       busy;
    logic       ack_overrun;

    tx_report_scheduler_if txif();

    tx_report_scheduler #(.STATUS_PERIOD_CYCLES(PERIOD)) dut (
        .clk         (clk),
        .rst         (rst),
        .alarm_evt   (alarm_evt),
        .sensor_snap (sensor_snap),
        .ack_req     (ack_req),
        .ack_code    (ack_code),
        .lights      (lights),
        .vents       (vents),
        .alarm_armed (alarm_armed),
        .door_open   (door_open),
        .tx          (txif.master),
        .busy        (busy),
        .ack_overrun (ack_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change only just after posedge, so valid&ready here means accepted next edge.
    always @(negedge clk) begin
        if (!rst && txif.tx_valid && txif.tx_ready) got.push_back(txif.tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic       alarm;
        logic [1:0] snap;
        logic       ack;
        logic [7:0] code;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mkv(input string n, input logic a, input logic [1:0] s,
                                 input logic k, input logic [7:0] c, input logic [39:0] e);
        vec_t v;
        v.name = n; v.alarm = a; v.snap = s; v.ack = k; v.code = c; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alarm_evt = 1'b0;
        ack_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got.delete();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic a, input logic [1:0] s, input logic k, input logic [7:0] c);
        alarm_evt = a; sensor_snap = s; ack_req = k; ack_code = c;
        @(posedge clk);
        #1;
        alarm_evt = 1'b0;
        ack_req = 1'b0;
    endtask

    // Collect the next 5 accepted bytes; on timeout returns all zeros.
    task automatic get_frame(input int budget, output logic [39:0] f);
        int n = 0;
        while (got.size() < 5 && n < budget) begin
            @(negedge clk);
            n++;
        end
        f = '0;
        if (got.size() >= 5) begin
            for (int i = 0; i < 5; i++) f = {f[31:0], got.pop_front()};
        end
    endtask

    // Next non-status frame, skipping periodic status frames.
    task automatic get_event_frame(output logic [39:0] f);
        logic [39:0] t;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            get_frame(60, t);
            if (t[31:24] != 8'h01) begin
                f = t;
                break;
            end
        end
    endtask

    initial begin
        logic [39:0] f;
        int          n;
        int          c1;
        int          stable;
        int          n_alarm;
        logic [39:0] f254, f255;

        rst = 1'b1;
        alarm_evt = 1'b0; sensor_snap = 2'b00;
        ack_req = 1'b0; ack_code = 8'h00;
        lights = 6'h05; vents = 4'h1; alarm_armed = 1'b1; door_open = 1'b0;
        txif.tx_ready = 1'b1;

        vecs[0] = mkv("tbl alarm snap2",  1'b1, 2'd2, 1'b0, 8'h00, 40'hA5_03_02_01_00);
        vecs[1] = mkv("tbl ack 3C",       1'b0, 2'd0, 1'b1, 8'h3C, 40'hA5_02_3C_00_3E);
        vecs[2] = mkv("tbl alarm snap3",  1'b1, 2'd3, 1'b0, 8'h00, 40'hA5_03_03_02_02);
        vecs[3] = mkv("tbl ack FF",       1'b0, 2'd0, 1'b1, 8'hFF, 40'hA5_02_FF_00_FD);
        vecs[4] = mkv("tbl alarm snap0",  1'b1, 2'd0, 1'b0, 8'h00, 40'hA5_03_00_03_00);
        vecs[5] = mkv("tbl ack 00",       1'b0, 2'd0, 1'b1, 8'h00, 40'hA5_02_00_00_02);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset tx_valid", 64'(txif.tx_valid), 64'd0);
        check("reset tx_data", 64'(txif.tx_data), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset ack_overrun", 64'(ack_overrun), 64'd0);

        // Table of single-frame requests.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pulse(vecs[i].alarm, vecs[i].snap, vecs[i].ack, vecs[i].code);
            get_frame(40, f);
            check(vecs[i].name, 64'(f), 64'(vecs[i].exp));
        end

        // Latency and backpressure on byte 2 of an ack frame.
        do_reset();
        txif.tx_ready = 1'b0;
        pulse(1'b0, 2'd0, 1'b1, 8'h0D);
        check("lat valid early", 64'(txif.tx_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat valid", 64'(txif.tx_valid), 64'd1);
        check("lat hdr", 64'(txif.tx_data), 64'hA5);
        check("lat busy", 64'(busy), 64'd1);
        txif.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        txif.tx_ready = 1'b0;
        stable = 0;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (txif.tx_valid && txif.tx_data == 8'h0D) stable++;
        end
        check("bp stable cycles", 64'(stable), 64'd7);
        txif.tx_ready = 1'b1;
        get_frame(40, f);
        check("bp frame", 64'(f), 64'hA5_02_0D_00_0F);

        // Priority: alarm and ack in the same cycle.
        do_reset();
        pulse(1'b1, 2'b01, 1'b1, 8'h0D);
        get_frame(40, f);
        check("prio alarm first", 64'(f), 64'hA5_03_01_01_03);
        get_frame(40, f);
        check("prio ack second", 64'(f), 64'hA5_02_0D_00_0F);

        // Ack overrun during an ongoing alarm frame.
        do_reset();
        pulse(1'b1, 2'd0, 1'b0, 8'h00);
        pulse(1'b0, 2'd0, 1'b1, 8'h09);
        check("ovr none yet", 64'(ack_overrun), 64'd0);
        pulse(1'b0, 2'd0, 1'b1, 8'h0A);
        check("ovr set", 64'(ack_overrun), 64'd1);
        get_frame(40, f);
        check("ovr alarm frame", 64'(f), 64'hA5_03_00_01_02);
        get_frame(40, f);
        check("ovr ack frame", 64'(f), 64'hA5_02_0A_00_08);
        repeat (30) @(posedge clk);
        #1;
        check("ovr single ack", 64'(got.size()), 64'd0);
        check("ovr sticky", 64'(ack_overrun), 64'd1);

        // Reset after byte 2 accepted, with an alarm pending.
        do_reset();
        pulse(1'b0, 2'd0, 1'b1, 8'h33);
        pulse(1'b1, 2'd1, 1'b0, 8'h00);
        n = 0;
        while (got.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst bytes before", 64'(got.size()), 64'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst valid drops", 64'(txif.tx_valid), 64'd0);
        check("rst busy drops", 64'(busy), 64'd0);
        check("rst data cleared", 64'(txif.tx_data), 64'd0);
        check("rst overrun cleared", 64'(ack_overrun), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        got.delete();
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("rst no frame", 64'(got.size()), 64'd0);
        pulse(1'b0, 2'd0, 1'b1, 8'h44);
        get_frame(40, f);
        check("rst new ack", 64'(f), 64'hA5_02_44_00_46);
        pulse(1'b1, 2'd2, 1'b0, 8'h00);
        get_frame(40, f);
        check("rst alarm cnt restart", 64'(f), 64'hA5_03_02_01_00);

        // Periodic status frames.
        lights = 6'h05; vents = 4'h1; alarm_armed = 1'b1; door_open = 1'b0;
        do_reset();
        n = 0;
        while (n < 150) begin
            @(posedge clk);
            #1;
            n++;
            if (txif.tx_valid) break;
        end
        check("status first cycle", 64'(n), 64'd101);
        c1 = cyc;
        get_frame(40, f);
        check("status frame 1", 64'(f), 64'hA5_01_05_11_15);
        lights = 6'h2A; vents = 4'hF; alarm_armed = 1'b0; door_open = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (txif.tx_valid) break;
        end
        check("status spacing", 64'(cyc - c1), 64'd100);
        get_frame(40, f);
        check("status frame 2", 64'(f), 64'hA5_01_2A_2F_04);

        // Alarm count wrap over 256 events.
        do_reset();
        n_alarm = 0;
        f254 = '0;
        f255 = '0;
        for (int i = 0; i < 256; i++) begin
            pulse(1'b1, 2'(i), 1'b0, 8'h00);
            get_event_frame(f);
            if (f[31:24] == 8'h03) n_alarm++;
            if (i == 254) f254 = f;
            if (i == 255) f255 = f;
        end
        check("wrap frame count", 64'(n_alarm), 64'd256);
        check("wrap cnt 255", 64'(f254), 64'hA5_03_02_FF_FE);
        check("wrap cnt 0", 64'(f255), 64'hA5_03_03_00_00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
